// File: rtl/mem_stage.sv
// MEM pipeline stage: word-addressed data memory with configurable access latency,
// branch/jump redirect resolution and the MEM/WB result register.
module mem_stage #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] Add_in,
    input  logic [31:0] ALU_in,
    input  logic [31:0] B2_in,
    input  logic [31:0] shift_left2_in,
    input  logic [4:0]  Mux_in,
    input  logic        ZF_in,
    input  logic        jump_in,
    input  logic        Branch_in,
    input  logic        MemToWrite_in,
    input  logic        MemRead_in,
    input  logic        Regwrite_in,
    input  logic        MemToReg_in,
    output logic        pc_src,
    output logic [31:0] pc_target,
    output logic        mem_stall,
    output logic        mem_misalign,
    output logic [31:0] MemWB_ReadData,
    output logic [31:0] MemWB_ALU,
    output logic [4:0]  MemWB_Mux,
    output logic        MemWB_Regwrite,
    output logic        MemWB_MemToReg
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;

    typedef enum logic {StIdle, StBusy} state_e;

    state_e          r_state;
    logic [CW-1:0]   r_cnt;
    logic [31:0]     r_mem [DEPTH];
    logic [31:0]     r_rdata;
    logic [31:0]     r_alu;
    logic [4:0]      r_mux;
    logic            r_regwrite;
    logic            r_memtoreg;
    logic            r_misalign;

    logic            w_access;
    logic            w_aligned;
    logic            w_go;
    logic [AW-1:0]   w_index;
    logic            w_stall;
    logic            w_complete;
    logic [31:0]     w_rdata;
    logic            w_unused;

    assign pc_src    = jump_in | (Branch_in & ZF_in);
    assign pc_target = jump_in ? shift_left2_in : Add_in;

    assign w_access  = MemRead_in | MemToWrite_in;
    assign w_aligned = (ALU_in[1:0] == 2'b00);
    assign w_go      = w_access & w_aligned;
    assign w_index   = ALU_in[AW+1:2];
    assign w_unused  = ^ALU_in[31:AW+2];

    always_comb begin
        w_stall    = 1'b0;
        w_complete = 1'b0;
        if (r_state == StIdle) begin
            w_stall    = w_go && (MEM_LAT > 1);
            w_complete = w_go && (MEM_LAT == 1);
        end else begin
            w_stall    = (r_cnt != '0);
            w_complete = w_go && (r_cnt == '0);
        end
    end

    // A combined load+store is treated as a store, so it never returns data.
    assign w_rdata = (w_complete && MemRead_in && !MemToWrite_in) ? r_mem[w_index] : '0;

    // Array has no reset; the write is gated so a reset edge aborts a pending store.
    always_ff @(posedge clk) begin
        if (rst_n && w_complete && MemToWrite_in) begin
            r_mem[w_index] <= B2_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_rdata    <= '0;
            r_alu      <= '0;
            r_mux      <= '0;
            r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_go && (MEM_LAT > 1)) begin
                        r_state <= StBusy;
                        r_cnt   <= CW'(MEM_LAT - 2);
                    end
                end
                StBusy: begin
                    if (r_cnt == '0) begin
                        r_state <= StIdle;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: r_state <= StIdle;
            endcase

            if (w_stall) begin
                r_rdata    <= '0;
                r_alu      <= '0;
                r_mux      <= '0;
                r_regwrite <= 1'b0;
                r_memtoreg <= 1'b0;
                r_misalign <= 1'b0;
            end else begin
                r_rdata    <= w_rdata;
                r_alu      <= ALU_in;
                r_mux      <= Mux_in;
                r_regwrite <= Regwrite_in;
                r_memtoreg <= MemToReg_in;
                r_misalign <= w_access & ~w_aligned;
            end
        end
    end

    assign mem_stall      = w_stall;
    assign mem_misalign   = r_misalign;
    assign MemWB_ReadData = r_rdata;
    assign MemWB_ALU      = r_alu;
    assign MemWB_Mux      = r_mux;
    assign MemWB_Regwrite = r_regwrite;
    assign MemWB_MemToReg = r_memtoreg;

endmodule
